// File: rtl/sp_frame_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sp_frame_sched                                             |
// | Description : Frame scheduler for the spectrum (SP) sample FIFO. Shares  |
// |               the single SP_fifo write port between two nWire sample     |
// |               sources. It captures fixed-length frames from one source   |
// |               at a time and alternates sources round-robin, with a       |
// |               programmable holdoff between frames. Each frame is tagged  |
// |               with its source, a sequence number and an abort flag.      |
// | Option      : define SP_DECIM_EN to write only every (decim+1)-th        |
// |               sample pulse of the selected source.                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sp_frame_sched #(
   parameter int FRAME_LEN = 4096,
   parameter int CNT_W     = 13
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  src_rdy,
   input  logic [1:0]  src_en,
   input  logic [15:0] holdoff,
   input  logic [3:0]  decim,
   input  logic        fifo_wrempty,
   input  logic        fifo_wrfull,
   output logic [1:0]  src_ack,
   output logic        wrreq,
   output logic        sel,
   output logic        frame_done,
   output logic        frame_err,
   output logic        frame_src,
   output logic [7:0]  frame_seq
);

   localparam logic [CNT_W-1:0] C_FRAME_LEN = CNT_W'(FRAME_LEN);

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_WAIT_EMPTY = 2'd1,
      ST_CAPTURE    = 2'd2,
      ST_HOLDOFF    = 2'd3
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;       // samples written in the current frame
   logic [15:0]      r_hold_cnt;  // clocks spent in HOLDOFF
   logic             r_rr_last;   // last source served (round-robin pointer)

   logic [1:0]       w_pulse;
   logic             w_sel_pulse;
   logic             w_take;
   logic             w_any_en;
   logic             w_next_src;
   logic             w_frame_full;

   // One pulse per rising edge of each ready line, however long it stays high.
   assign w_pulse      = src_rdy & ~src_ack;
   assign w_sel_pulse  = w_pulse[sel];
   assign w_any_en     = |src_en;
   // Prefer the source after the last served one; fall back to the same one
   // when it is the only source enabled.
   assign w_next_src   = src_en[~r_rr_last] ? ~r_rr_last : r_rr_last;
   assign w_frame_full = (r_cnt == C_FRAME_LEN);

`ifdef SP_DECIM_EN
   logic [3:0] r_dec_phase;

   // Only phase 0 of each (decim+1)-pulse group is written.
   assign w_take = w_sel_pulse & (r_dec_phase == 4'd0);

   // Decimation phase restarts on every CAPTURE entry so the first pulse is kept.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_dec_phase <= 4'd0;
      end else if (r_state == ST_WAIT_EMPTY) begin
         r_dec_phase <= 4'd0;
      end else if ((r_state == ST_CAPTURE) && w_sel_pulse && !fifo_wrfull && !w_frame_full) begin
         r_dec_phase <= (r_dec_phase == decim) ? 4'd0 : r_dec_phase + 4'd1;
      end
   end
`else
   logic w_unused_decim;

   // Without decimation every pulse of the selected source is written.
   assign w_take         = w_sel_pulse;
   assign w_unused_decim = ^decim;
`endif

   // Registered copy of the ready lines; doubles as the edge-detect history.
   always_ff @(posedge clk) begin
      if (reset) begin
         src_ack <= 2'b00;
      end else begin
         src_ack <= src_rdy;
      end
   end

   // Frame scheduling state machine with registered strobes and frame tags.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_hold_cnt <= 16'd0;
         r_rr_last  <= 1'b1;
         wrreq      <= 1'b0;
         sel        <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         frame_src  <= 1'b0;
         frame_seq  <= 8'd0;
      end else begin
         wrreq      <= 1'b0;
         frame_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               // src_en is only looked at here, so mid-frame changes wait.
               if (w_any_en) begin
                  sel       <= w_next_src;
                  r_rr_last <= w_next_src;
                  r_state   <= ST_WAIT_EMPTY;
               end
            end
            ST_WAIT_EMPTY: begin
               // Host must have drained the previous frame before we refill.
               if (fifo_wrempty) begin
                  r_cnt   <= '0;
                  r_state <= ST_CAPTURE;
               end
            end
            ST_CAPTURE: begin
               if (w_frame_full) begin
                  // Final write went out last clock: close the frame cleanly.
                  frame_done <= 1'b1;
                  frame_err  <= 1'b0;
                  frame_src  <= sel;
                  frame_seq  <= frame_seq + 8'd1;
                  r_hold_cnt <= 16'd0;
                  r_state    <= ST_HOLDOFF;
               end else if (fifo_wrfull) begin
                  // Overflow wins over a coincident pulse: abort the frame.
                  frame_done <= 1'b1;
                  frame_err  <= 1'b1;
                  frame_src  <= sel;
                  frame_seq  <= frame_seq + 8'd1;
                  r_hold_cnt <= 16'd0;
                  r_state    <= ST_HOLDOFF;
               end else if (w_take) begin
                  wrreq <= 1'b1;
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_HOLDOFF: begin
               if (r_hold_cnt == holdoff) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_hold_cnt <= r_hold_cnt + 16'd1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sp_frame_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_sp_frame_sched                                          |
// | Description : Self-checking bench for sp_frame_sched. Expected frame     |
// |               tags are queued as stimulus is issued and matched against |
// |               each frame_done; directed checks cover latency, reset,    |
// |               overflow abort and holdoff spacing.                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_sp_frame_sched;

   localparam int C_FRAME_LEN = 4096;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  src_rdy;
   logic [1:0]  src_en;
   logic [15:0] holdoff;
   logic [3:0]  decim;
   logic        fifo_wrempty;
   logic        fifo_wrfull;
   logic [1:0]  src_ack;
   logic        wrreq;
   logic        sel;
   logic        frame_done;
   logic        frame_err;
   logic        frame_src;
   logic [7:0]  frame_seq;

   typedef struct {
      logic       err;
      logic       src;
      logic [7:0] seq;
      int         nw;
   } exp_t;

   exp_t q[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int wr_cnt = 0;
   int done_cnt = 0;
   int last_done_cyc = 0;
   int first_wr_cyc = 0;
   bit wr_seen_after_done = 1'b0;

   sp_frame_sched #(.FRAME_LEN(C_FRAME_LEN), .CNT_W(13)) dut (
      .clk          (clk),
      .reset        (reset),
      .src_rdy      (src_rdy),
      .src_en       (src_en),
      .holdoff      (holdoff),
      .decim        (decim),
      .fifo_wrempty (fifo_wrempty),
      .fifo_wrfull  (fifo_wrfull),
      .src_ack      (src_ack),
      .wrreq        (wrreq),
      .sel          (sel),
      .frame_done   (frame_done),
      .frame_err    (frame_err),
      .frame_src    (frame_src),
      .frame_seq    (frame_seq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input logic [1:0] m);
      src_rdy = m;
      @(negedge clk);
      src_rdy = 2'b00;
      @(negedge clk);
   endtask

   // Both sources pulse every 2 clocks, in opposite phases.
   task automatic alt_pulse();
      src_rdy = 2'b01;
      @(negedge clk);
      src_rdy = 2'b10;
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      src_rdy = 2'b00;
      tick(2);
      reset   = 1'b0;
   endtask

   task automatic push_exp(input logic err, input logic src, input logic [7:0] seq, input int nw);
      exp_t e;
      e.err = err;
      e.src = src;
      e.seq = seq;
      e.nw  = nw;
      q.push_back(e);
   endtask

   task automatic wait_done(input int target, input int budget);
      int n = 0;
      while (done_cnt < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("done_count", done_cnt, target);
   endtask

   initial begin
      int n_wr;
      int gap;
      reset        = 1'b1;
      src_rdy      = 2'b00;
      src_en       = 2'b00;
      holdoff      = 16'd0;
`ifdef SP_DECIM_EN
      decim        = 4'd0;
`else
      decim        = 4'd3;
`endif
      fifo_wrempty = 1'b1;
      fifo_wrfull  = 1'b0;

      // Scoreboard monitor: counts writes, matches each frame_done to a record.
      fork
         forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
               wr_cnt = 0;
            end else begin
               if (wrreq) begin
                  wr_cnt++;
                  if (!wr_seen_after_done) begin
                     first_wr_cyc       = cyc;
                     wr_seen_after_done = 1'b1;
                  end
               end
               if (frame_done) begin
                  done_cnt++;
                  last_done_cyc      = cyc;
                  wr_seen_after_done = 1'b0;
                  if (q.size() == 0) begin
                     chk("unexpected_done", 32'd1, 32'd0);
                  end else begin
                     exp_t e;
                     e = q.pop_front();
                     chk("frame_err", frame_err, e.err);
                     chk("frame_src", frame_src, e.src);
                     chk("frame_seq", frame_seq, e.seq);
                     chk("done_sel", sel, e.src);
                     chk("frame_writes", wr_cnt, e.nw);
                  end
                  wr_cnt = 0;
               end
            end
         end
      join_none

      // Reset state
      tick(3);
      chk("rst_src_ack", src_ack, 2'b00);
      chk("rst_wrreq", wrreq, 1'b0);
      chk("rst_sel", sel, 1'b0);
      chk("rst_frame_done", frame_done, 1'b0);
      chk("rst_frame_err", frame_err, 1'b0);
      chk("rst_frame_src", frame_src, 1'b0);
      chk("rst_frame_seq", frame_seq, 8'd0);
      reset = 1'b0;

      // Single source, full frame
      src_en = 2'b01;
      push_exp(1'b0, 1'b0, 8'd1, C_FRAME_LEN);
      tick(4);
      chk("t1_sel", sel, 1'b0);
      for (int i = 0; i < C_FRAME_LEN; i++) pulse(2'b01);
      wait_done(1, 20);

      // Round-robin over two sources with interleaved ready pulses
      do_reset();
      src_en = 2'b11;
      push_exp(1'b0, 1'b0, 8'd1, C_FRAME_LEN);
      push_exp(1'b0, 1'b1, 8'd2, C_FRAME_LEN);
      tick(4);
      for (int i = 0; i < 9000 && done_cnt < 3; i++) alt_pulse();
      src_rdy = 2'b00;
      chk("t2_done_count", done_cnt, 3);

      // Ready held high for 10 clocks: one write, ack delayed by one clock
      do_reset();
      src_en = 2'b01;
      tick(4);
      n_wr = 0;
      src_rdy = 2'b01;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("t3_ack_follow", src_ack, 2'b01);
         if (k == 0) chk("t3_wr_latency", wrreq, 1'b1);
         if (wrreq) n_wr++;
      end
      src_rdy = 2'b00;
      @(negedge clk);
      chk("t3_ack_fall", src_ack, 2'b00);
      if (wrreq) n_wr++;
      chk("t3_wr_once", n_wr, 1);

      // Overflow abort after 1000 writes, then WAIT_EMPTY gating
      do_reset();
      src_en  = 2'b01;
      holdoff = 16'd5;
      push_exp(1'b1, 1'b0, 8'd1, 1000);
      tick(4);
      for (int i = 0; i < 1000; i++) pulse(2'b01);
      fifo_wrfull  = 1'b1;
      fifo_wrempty = 1'b0;
      n_wr = 0;
      for (int i = 0; i < 20; i++) begin
         src_rdy = 2'b01;
         @(negedge clk);
         if (wrreq) n_wr++;
         src_rdy = 2'b00;
         @(negedge clk);
         if (wrreq) n_wr++;
      end
      chk("t4_no_wr_after_full", n_wr, 0);
      chk("t4_done_count", done_cnt, 4);
      fifo_wrfull = 1'b0;
      n_wr = 0;
      for (int i = 0; i < 10; i++) begin
         src_rdy = 2'b01;
         @(negedge clk);
         if (wrreq) n_wr++;
         src_rdy = 2'b00;
         @(negedge clk);
         if (wrreq) n_wr++;
      end
      chk("t4_wait_empty_blocks", n_wr, 0);
      fifo_wrempty = 1'b1;
      n_wr = 0;
      for (int i = 0; i < 6; i++) begin
         src_rdy = 2'b01;
         @(negedge clk);
         if (wrreq) n_wr++;
         src_rdy = 2'b00;
         @(negedge clk);
         if (wrreq) n_wr++;
      end
      chk("t4_resume_after_empty", (n_wr > 0), 1'b1);

      // Holdoff spacing, then reset in the middle of the next capture
      do_reset();
      src_en  = 2'b01;
      holdoff = 16'd100;
      push_exp(1'b0, 1'b0, 8'd1, C_FRAME_LEN);
      tick(4);
      for (int i = 0; i < 4200 && done_cnt < 5; i++) pulse(2'b01);
      chk("t5_done_count", done_cnt, 5);
      for (int i = 0; i < 200 && !wr_seen_after_done; i++) pulse(2'b01);
      gap = first_wr_cyc - last_done_cyc;
      chk("t5_holdoff_gap_min", (wr_seen_after_done && gap >= 103), 1'b1);
      chk("t5_holdoff_gap_max", (gap <= 110), 1'b1);
      for (int i = 0; i < 5; i++) pulse(2'b01);
      reset   = 1'b1;
      src_rdy = 2'b11;
      @(negedge clk);
      chk("t5_rst_src_ack", src_ack, 2'b00);
      chk("t5_rst_wrreq", wrreq, 1'b0);
      chk("t5_rst_sel", sel, 1'b0);
      chk("t5_rst_frame_done", frame_done, 1'b0);
      chk("t5_rst_frame_err", frame_err, 1'b0);
      chk("t5_rst_frame_src", frame_src, 1'b0);
      chk("t5_rst_frame_seq", frame_seq, 8'd0);
      src_rdy = 2'b00;
      src_en  = 2'b00;
      @(negedge clk);
      reset = 1'b0;
      tick(20);
      chk("t5_no_done_after_reset", done_cnt, 5);

`ifdef SP_DECIM_EN
      // Decimation by 4: first pulse written, 4096 writes from 16384 pulses
      do_reset();
      src_en  = 2'b01;
      holdoff = 16'd0;
      decim   = 4'd3;
      push_exp(1'b0, 1'b0, 8'd1, C_FRAME_LEN);
      tick(4);
      src_rdy = 2'b01;
      @(negedge clk);
      chk("t6_decim_first", wrreq, 1'b1);
      src_rdy = 2'b00;
      @(negedge clk);
      for (int i = 1; i < 4 * C_FRAME_LEN; i++) pulse(2'b01);
      wait_done(6, 20);
`endif

      chk("sb_empty", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
